// File: rtl/maxpool_pkg.sv
// Shared maxpool definitions: FSM state encoding and feature-map geometry helpers.
// Used by the maxpool core, the result writer and the RAM read controller.
package maxpool_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic int out_dim(input int dim, input int pool);
    return dim / pool;
  endfunction

  function automatic int pix_count(input int h, input int w, input int pool);
    return out_dim(h, pool) * out_dim(w, pool);
  endfunction

  // Bits needed to index n values; never below 1 so single-entry counters stay legal.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/pool_wr_addr_gen.sv
// Pixel/channel counters for the result writer. Walks the frame in either channel-major or
// channel-interleaved order and produces the RAM word address plus a last-element flag.
module pool_wr_addr_gen
  import maxpool_pkg::*;
#(
  parameter int                PIX       = 9,
  parameter int                CH        = 1,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                CH_STRIDE = PIX,
  parameter int                CH_ILV    = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam int PIX_W = clog2(PIX);
  localparam int CH_W  = clog2(CH);

  logic [PIX_W-1:0] pix;
  logic [CH_W-1:0]  ch;
  logic             pix_end;
  logic             ch_end;

  assign pix_end = (pix == PIX_W'(PIX - 1));
  assign ch_end  = (ch == CH_W'(CH - 1));
  assign last    = pix_end & ch_end;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pix <= '0;
      ch  <= '0;
    end else if (clr) begin
      pix <= '0;
      ch  <= '0;
    end else if (step) begin
      if (CH_ILV == 0) begin
        if (pix_end) begin
          pix <= '0;
          ch  <= ch + 1'b1;
        end else begin
          pix <= pix + 1'b1;
        end
      end else begin
        if (ch_end) begin
          ch  <= '0;
          pix <= pix + 1'b1;
        end else begin
          ch <= ch + 1'b1;
        end
      end
    end
  end

  // Wraps modulo 2^ADDR_W by construction.
  assign addr = BASE_ADDR + ADDR_W'(ch) * ADDR_W'(CH_STRIDE) + ADDR_W'(pix);

endmodule

// File: rtl/pool_result_writer.sv
// Writes one multi-channel pooled feature map from a valid/ready stream into result RAM,
// with start/abort control, a word counter and a sticky frame-complete interrupt.
module pool_result_writer
  import maxpool_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                H         = 6,
  parameter int                W         = 6,
  parameter int                POOL      = 2,
  parameter int                CH        = 1,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                CH_STRIDE = pix_count(H, W, POOL),
  parameter int                CH_ILV    = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              intr,
  input  logic              intr_clr,
  output logic [15:0]       wr_count,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wr
);

  localparam int PIX = pix_count(H, W, POOL);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              run_q;
  logic              arm;
  logic              hs;
  logic              done_entry;
  logic [ADDR_W-1:0] gen_addr;
  logic              gen_last;

  assign arm        = (state == IDLE) & start;
  // Abort suppresses a same-cycle handshake so that word is never written.
  assign hs         = in_valid & run_q & ~abort;
  assign done_entry = (state == RUN) & (state_nxt == DONE);

  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN: begin
        if (abort)                state_nxt = IDLE;
        else if (hs && gen_last)  state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      run_q <= 1'b0;
    end else begin
      state <= state_nxt;
      run_q <= (state_nxt == RUN);
    end
  end

  assign busy     = run_q;
  assign in_ready = run_q;

  pool_wr_addr_gen #(
    .PIX       (PIX),
    .CH        (CH),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR),
    .CH_STRIDE (CH_STRIDE),
    .CH_ILV    (CH_ILV)
  ) u_addr_gen (
    .clk  (clk),
    .rstn (rstn),
    .clr  (arm),
    .step (hs),
    .addr (gen_addr),
    .last (gen_last)
  );

  // Address and data hold their last value between writes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ram_en   <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_wr   <= '0;
    end else begin
      ram_en <= hs;
      ram_we <= hs;
      if (hs) begin
        ram_addr <= gen_addr;
        ram_wr   <= in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      intr     <= 1'b0;
      wr_count <= '0;
    end else begin
      if (done_entry)    intr <= 1'b1;
      else if (intr_clr) intr <= 1'b0;

      if (arm)                             wr_count <= '0;
      else if (hs && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_pool_result_writer.sv
// Scoreboard bench for pool_result_writer: three instances cover default, channel-major and
// channel-interleaved configurations; expected writes are queued at accept time.
module tb_pool_result_writer;

  localparam int ND = 3;

  typedef struct {
    int          id;
    logic [31:0] addr;
    logic [7:0]  data;
  } exp_t;

  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  logic        start    [ND];
  logic        abort    [ND];
  logic        intr_clr [ND];
  logic        in_valid [ND];
  logic [7:0]  in_data  [ND];
  logic        busy     [ND];
  logic        intr     [ND];
  logic        in_ready [ND];
  logic        ram_en   [ND];
  logic        ram_we   [ND];
  logic [31:0] ram_addr [ND];
  logic [7:0]  ram_wr   [ND];
  logic [15:0] wr_count [ND];

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_writes [ND];
  logic hs_last  [ND];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    pool_result_writer #(
      .DATA_W    (8),
      .H         (6),
      .W         (6),
      .POOL      (2),
      .CH        (g == 0 ? 1 : 3),
      .ADDR_W    (32),
      .BASE_ADDR (g == 0 ? 32'h0 : 32'h100),
      .CH_STRIDE (g == 0 ? 9 : 16),
      .CH_ILV    (g == 2 ? 1 : 0)
    ) u_dut (
      .clk      (clk),
      .rstn     (rstn),
      .start    (start[g]),
      .abort    (abort[g]),
      .busy     (busy[g]),
      .intr     (intr[g]),
      .intr_clr (intr_clr[g]),
      .wr_count (wr_count[g]),
      .in_data  (in_data[g]),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .ram_en   (ram_en[g]),
      .ram_we   (ram_we[g]),
      .ram_addr (ram_addr[g]),
      .ram_wr   (ram_wr[g])
    );
  end

  // Reference address: instance 0 is the 3x3 single-channel default; 1 and 2 use three
  // channels at base 0x100 with stride 16, channel-major and interleaved respectively.
  function automatic logic [31:0] exp_addr(input int d, input int k);
    int ch, pix, base, stride;
    base   = (d == 0) ? 0 : 'h100;
    stride = (d == 0) ? 9 : 16;
    if (d == 2) begin
      ch  = k % 3;
      pix = k / 3;
    end else begin
      ch  = k / 9;
      pix = k % 9;
    end
    return 32'(base + ch * stride + pix);
  endfunction

  // Write monitor: strobes must follow accepted handshakes by exactly one cycle.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < ND; d++) begin
      if (!rstn) begin
        hs_last[d] = 1'b0;
      end else begin
        checks++;
        if (ram_en[d] !== hs_last[d] || ram_we[d] !== hs_last[d]) begin
          errors++;
          $display("FAIL wr_strobe dut%0d t=%0t ram_en=%b ram_we=%b expected=%b",
                   d, $time, ram_en[d], ram_we[d], hs_last[d]);
        end
        if (ram_en[d] === 1'b1) begin
          n_writes[d]++;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL wr_unexpected dut%0d t=%0t addr=%h data=%h expected=none",
                     d, $time, ram_addr[d], ram_wr[d]);
          end else begin
            e = sb.pop_front();
            if (e.id != d || ram_addr[d] !== e.addr || ram_wr[d] !== e.data) begin
              errors++;
              $display("FAIL wr_data dut%0d t=%0t addr=%h data=%h expected dut%0d addr=%h data=%h",
                       d, $time, ram_addr[d], ram_wr[d], e.id, e.addr, e.data);
            end
          end
        end
        hs_last[d] = in_valid[d] & in_ready[d] & ~abort[d];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int d);
    start[d] = 1'b1;
    step();
    start[d] = 1'b0;
    checks++;
    if (busy[d] !== 1'b1 || in_ready[d] !== 1'b1 || wr_count[d] !== 16'd0) begin
      errors++;
      $display("FAIL start dut%0d busy=%b in_ready=%b wr_count=%0d expected 1 1 0",
               d, busy[d], in_ready[d], wr_count[d]);
    end
  endtask

  // Offers words first..first+n-1 with the given valid duty (percent).
  task automatic send_words(input int d, input int n, input int first,
                            input logic [7:0] seed, input int duty);
    int sent, cyc;
    sent = 0;
    cyc  = 0;
    while (sent < n && cyc < 1000) begin
      in_valid[d] = ($urandom_range(99) < duty);
      in_data[d]  = seed + 8'(first + sent);
      if (in_valid[d] && in_ready[d]) begin
        sb.push_back('{d, exp_addr(d, first + sent), seed + 8'(first + sent)});
        sent++;
      end
      step();
      cyc++;
    end
    in_valid[d] = 1'b0;
    checks++;
    if (sent != n) begin
      errors++;
      $display("FAIL send_timeout dut%0d accepted=%0d expected=%0d", d, sent, n);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int pass = 0; pass < 2; pass++) begin
      for (int d = 0; d < ND; d++) begin
        checks++;
        if ({busy[d], intr[d], in_ready[d], ram_en[d], ram_we[d]} !== 5'b0 ||
            ram_addr[d] !== 32'h0 || ram_wr[d] !== 8'h0 || wr_count[d] !== 16'h0) begin
          errors++;
          $display("FAIL reset_state dut%0d pass%0d busy=%b intr=%b rdy=%b en=%b we=%b addr=%h wr=%h cnt=%0d expected all 0",
                   d, pass, busy[d], intr[d], in_ready[d], ram_en[d], ram_we[d],
                   ram_addr[d], ram_wr[d], wr_count[d]);
        end
      end
      rstn = 1'b1;
      step();
    end
  endtask

  task automatic test_basic();
    start_frame(0);
    send_words(0, 8, 0, 8'h11, 100);
    checks++;
    if (intr[0] !== 1'b0) begin
      errors++;
      $display("FAIL basic_intr_early intr=%b expected=0", intr[0]);
    end
    send_words(0, 1, 8, 8'h11, 100);
    checks++;
    if (intr[0] !== 1'b1 || ram_en[0] !== 1'b1 || ram_wr[0] !== 8'h19) begin
      errors++;
      $display("FAIL basic_last_write intr=%b ram_en=%b ram_wr=%h expected 1 1 19",
               intr[0], ram_en[0], ram_wr[0]);
    end
    step();
    checks++;
    if (intr[0] !== 1'b1 || busy[0] !== 1'b0 || in_ready[0] !== 1'b0 || wr_count[0] !== 16'd9) begin
      errors++;
      $display("FAIL basic_after intr=%b busy=%b rdy=%b cnt=%0d expected 1 0 0 9",
               intr[0], busy[0], in_ready[0], wr_count[0]);
    end
  endtask

  task automatic test_multi_ch(input int d, input logic [7:0] seed);
    start_frame(d);
    send_words(d, 27, 0, seed, 100);
    step();
    checks++;
    if (wr_count[d] !== 16'd27 || intr[d] !== 1'b1 || busy[d] !== 1'b0) begin
      errors++;
      $display("FAIL multi_ch dut%0d cnt=%0d intr=%b busy=%b expected 27 1 0",
               d, wr_count[d], intr[d], busy[d]);
    end
  endtask

  task automatic test_gaps();
    intr_clr[0] = 1'b1;
    step();
    intr_clr[0] = 1'b0;
    checks++;
    if (intr[0] !== 1'b0) begin
      errors++;
      $display("FAIL gaps_clr intr=%b expected=0", intr[0]);
    end
    n_writes[0] = 0;
    start_frame(0);
    send_words(0, 9, 0, 8'hA0, 50);
    step();
    step();
    checks++;
    if (n_writes[0] != 9 || intr[0] !== 1'b1) begin
      errors++;
      $display("FAIL gaps_count writes=%0d intr=%b expected 9 1", n_writes[0], intr[0]);
    end
  endtask

  task automatic test_abort();
    intr_clr[1] = 1'b1;
    step();
    intr_clr[1] = 1'b0;
    start_frame(1);
    send_words(1, 4, 0, 8'h20, 100);
    abort[1]    = 1'b1;
    in_valid[1] = 1'b1;
    in_data[1]  = 8'hEE;
    step();
    abort[1] = 1'b0;
    checks++;
    if (busy[1] !== 1'b0 || in_ready[1] !== 1'b0 || intr[1] !== 1'b0 || wr_count[1] !== 16'd4) begin
      errors++;
      $display("FAIL abort_state busy=%b rdy=%b intr=%b cnt=%0d expected 0 0 0 4",
               busy[1], in_ready[1], intr[1], wr_count[1]);
    end
    step();
    step();
    in_valid[1] = 1'b0;
    checks++;
    if (intr[1] !== 1'b0) begin
      errors++;
      $display("FAIL abort_intr intr=%b expected=0", intr[1]);
    end
    start_frame(1);
    send_words(1, 2, 0, 8'h30, 100);
    start[1] = 1'b1;
    step();
    start[1] = 1'b0;
    send_words(1, 25, 2, 8'h30, 100);
    step();
    checks++;
    if (wr_count[1] !== 16'd27 || intr[1] !== 1'b1) begin
      errors++;
      $display("FAIL abort_restart cnt=%0d intr=%b expected 27 1", wr_count[1], intr[1]);
    end
  endtask

  task automatic test_intr_clr();
    intr_clr[0] = 1'b1;
    step();
    intr_clr[0] = 1'b0;
    start_frame(0);
    send_words(0, 8, 0, 8'h50, 100);
    in_valid[0] = 1'b1;
    in_data[0]  = 8'h58;
    intr_clr[0] = 1'b1;
    sb.push_back('{0, exp_addr(0, 8), 8'h58});
    step();
    in_valid[0] = 1'b0;
    checks++;
    if (intr[0] !== 1'b1) begin
      errors++;
      $display("FAIL intr_set_wins intr=%b expected=1", intr[0]);
    end
    step();
    intr_clr[0] = 1'b0;
    checks++;
    if (intr[0] !== 1'b0) begin
      errors++;
      $display("FAIL intr_clear intr=%b expected=0", intr[0]);
    end
  endtask

  task automatic test_reset_mid();
    start_frame(2);
    send_words(2, 5, 0, 8'h60, 100);
    in_valid[2] = 1'b1;
    in_data[2]  = 8'h65;
    sb.push_back('{2, exp_addr(2, 5), 8'h65});
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    sb.delete();
    in_valid[2] = 1'b0;
    for (int d = 0; d < ND; d++) begin
      checks++;
      if ({busy[d], intr[d], in_ready[d], ram_en[d], ram_we[d]} !== 5'b0 ||
          ram_addr[d] !== 32'h0 || ram_wr[d] !== 8'h0 || wr_count[d] !== 16'h0) begin
        errors++;
        $display("FAIL reset_async dut%0d busy=%b intr=%b rdy=%b en=%b addr=%h wr=%h cnt=%0d expected all 0",
                 d, busy[d], intr[d], in_ready[d], ram_en[d], ram_addr[d], ram_wr[d], wr_count[d]);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ram_en[2] !== 1'b0 || ram_addr[2] !== 32'h0) begin
      errors++;
      $display("FAIL reset_pending ram_en=%b addr=%h expected 0 0", ram_en[2], ram_addr[2]);
    end
    rstn = 1'b1;
    step();
    test_multi_ch(2, 8'h70);
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin
      start[d]    = 1'b0;
      abort[d]    = 1'b0;
      intr_clr[d] = 1'b0;
      in_valid[d] = 1'b0;
      in_data[d]  = 8'h0;
      n_writes[d] = 0;
      hs_last[d]  = 1'b0;
    end
    test_reset();
    test_basic();
    test_multi_ch(1, 8'h40);
    test_multi_ch(2, 8'h80);
    test_gaps();
    test_abort();
    test_intr_clr();
    test_reset_mid();
    step();
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover pending=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
